// File: rtl/gpu_pkg.sv
// Shared GPU block types: rectangle fill engine state encoding.
package gpu_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_e;
endpackage

// File: rtl/rect_normalize.sv
// Clamps two inclusive bounds to RES-1, then orders them so lo <= hi.
module rect_normalize #(
  parameter int W   = 9,
  parameter int RES = 400
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);
  localparam logic [W-1:0] MAXV = W'(RES - 1);

  logic [W-1:0] ac, bc;

  assign ac = (a > MAXV) ? MAXV : a;
  assign bc = (b > MAXV) ? MAXV : b;
  assign lo = (ac > bc) ? bc : ac;
  assign hi = (ac > bc) ? ac : bc;
endmodule

// File: rtl/rect_fill.sv
// Rectangle fill engine: emits one framebuffer pixel write per cycle in
// row-major order over a clamped, ordered rectangle.
module rect_fill
  import gpu_pkg::*;
#(
  parameter int RESOLUTION_X   = 400,
  parameter int RESOLUTION_Y   = 300,
  parameter int PALETTE_LENGTH = 256,
  localparam int XW = $clog2(RESOLUTION_X),
  localparam int YW = $clog2(RESOLUTION_Y),
  localparam int CW = $clog2(PALETTE_LENGTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [XW-1:0] cmd_x0_i,
  input  logic [XW-1:0] cmd_x1_i,
  input  logic [YW-1:0] cmd_y0_i,
  input  logic [YW-1:0] cmd_y1_i,
  input  logic [CW-1:0] cmd_color_i,
  output logic          we_o,
  output logic [XW-1:0] wr_pxl_x_o,
  output logic [YW-1:0] wr_pxl_y_o,
  output logic [CW-1:0] wr_palette_index_o,
  output logic          busy_o,
  output logic          done_o
);
  fill_state_e   state;
  logic [XW-1:0] xmin, xmax, nx_lo, nx_hi;
  logic [YW-1:0] ymax, ny_lo, ny_hi;

  rect_normalize #(.W(XW), .RES(RESOLUTION_X)) u_norm_x (
    .a(cmd_x0_i), .b(cmd_x1_i), .lo(nx_lo), .hi(nx_hi));
  rect_normalize #(.W(YW), .RES(RESOLUTION_Y)) u_norm_y (
    .a(cmd_y0_i), .b(cmd_y1_i), .lo(ny_lo), .hi(ny_hi));

  // Held low during reset so every output reads 0 while reset is applied.
  assign cmd_ready_o = (state == IDLE) && !reset_i;

  // The write-address outputs double as the scan counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state              <= IDLE;
      we_o               <= 1'b0;
      wr_pxl_x_o         <= '0;
      wr_pxl_y_o         <= '0;
      wr_palette_index_o <= '0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
      xmin               <= '0;
      xmax               <= '0;
      ymax               <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (cmd_valid_i) begin
            state              <= FILL;
            busy_o             <= 1'b1;
            xmin               <= nx_lo;
            xmax               <= nx_hi;
            ymax               <= ny_hi;
            we_o               <= 1'b1;
            wr_pxl_x_o         <= nx_lo;
            wr_pxl_y_o         <= ny_lo;
            wr_palette_index_o <= cmd_color_i;
          end
        end
        FILL: begin
          if (wr_pxl_x_o == xmax && wr_pxl_y_o == ymax) begin
            state              <= DONE;
            we_o               <= 1'b0;
            wr_pxl_x_o         <= '0;
            wr_pxl_y_o         <= '0;
            wr_palette_index_o <= '0;
            done_o             <= 1'b1;
          end else if (wr_pxl_x_o == xmax) begin
            wr_pxl_x_o <= xmin;
            wr_pxl_y_o <= wr_pxl_y_o + 1'b1;
          end else begin
            wr_pxl_x_o <= wr_pxl_x_o + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rect_fill.sv
// Directed bench for rect_fill: default 400x300 instance plus a small
// 260x140 instance used for the full-screen sweep.
module tb_rect_fill;
  logic       clk = 1'b0;
  logic       reset_i;
  logic       valid_d, valid_s, sel;
  logic [8:0] x0, x1, y0, y1;
  logic [7:0] color;

  logic       d_ready, d_we, d_busy, d_done;
  logic [8:0] d_x, d_y;
  logic [7:0] d_pal;
  logic       s_ready, s_we, s_busy, s_done;
  logic [8:0] s_x;
  logic [7:0] s_y;
  logic [7:0] s_pal;

  logic       m_ready, m_we, m_busy, m_done;
  logic [8:0] m_x, m_y;
  logic [7:0] m_pal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rect_fill dut (
    .clk_i(clk), .reset_i(reset_i), .cmd_valid_i(valid_d), .cmd_ready_o(d_ready),
    .cmd_x0_i(x0), .cmd_x1_i(x1), .cmd_y0_i(y0), .cmd_y1_i(y1), .cmd_color_i(color),
    .we_o(d_we), .wr_pxl_x_o(d_x), .wr_pxl_y_o(d_y), .wr_palette_index_o(d_pal),
    .busy_o(d_busy), .done_o(d_done));

  rect_fill #(.RESOLUTION_X(260), .RESOLUTION_Y(140), .PALETTE_LENGTH(256)) dut_s (
    .clk_i(clk), .reset_i(reset_i), .cmd_valid_i(valid_s), .cmd_ready_o(s_ready),
    .cmd_x0_i(x0), .cmd_x1_i(x1), .cmd_y0_i(y0[7:0]), .cmd_y1_i(y1[7:0]),
    .cmd_color_i(color), .we_o(s_we), .wr_pxl_x_o(s_x), .wr_pxl_y_o(s_y),
    .wr_palette_index_o(s_pal), .busy_o(s_busy), .done_o(s_done));

  assign m_ready = sel ? s_ready : d_ready;
  assign m_we    = sel ? s_we    : d_we;
  assign m_busy  = sel ? s_busy  : d_busy;
  assign m_done  = sel ? s_done  : d_done;
  assign m_x     = sel ? s_x     : d_x;
  assign m_y     = sel ? {1'b0, s_y} : d_y;
  assign m_pal   = sel ? s_pal   : d_pal;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One comparison per cycle covering the whole write port plus status.
  task automatic chk_px(input string nm, input logic we, input int x, input int y,
                        input int c, input logic dn, input logic bz);
    checks++;
    if (m_we !== we || m_x != 9'(x) || m_y != 9'(y) || m_pal != 8'(c) ||
        m_done !== dn || m_busy !== bz) begin
      errors++;
      $display("FAIL %s: got we=%0b x=%0d y=%0d c=%0h done=%0b busy=%0b expected we=%0b x=%0d y=%0d c=%0h done=%0b busy=%0b",
               nm, m_we, m_x, m_y, m_pal, m_done, m_busy, we, x, y, c, dn, bz);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    x0 = 9'h1AB; x1 = 9'h0C3; y0 = 9'h155; y1 = 9'h02E; color = 8'hE7;
  endtask

  // Issues one command and checks every write against a row-major sweep of
  // the hand-computed expected bounds, then the DONE and return-to-IDLE cycles.
  task automatic run_fill(input string nm, input logic s,
                          input int ax0, input int ax1, input int ay0, input int ay1,
                          input int col, input int exmin, input int exmax,
                          input int eymin, input int eymax);
    int n, w;
    sel = s;
    n = 0;
    while (!m_ready && n < 10) begin step(); n++; end
    chk({nm, " ready_before"}, int'(m_ready), 1);
    x0 = 9'(ax0); x1 = 9'(ax1); y0 = 9'(ay0); y1 = 9'(ay1); color = 8'(col);
    valid_d = !s; valid_s = s;
    step();
    valid_d = 1'b0; valid_s = 1'b0;
    scramble();
    w = 0;
    for (int yy = eymin; yy <= eymax; yy++)
      for (int xx = exmin; xx <= exmax; xx++) begin
        chk_px({nm, " write"}, 1'b1, xx, yy, col, 1'b0, 1'b1);
        if (w == 0) chk({nm, " ready_in_fill"}, int'(m_ready), 0);
        w++;
        step();
      end
    chk_px({nm, " done_cycle"}, 1'b0, 0, 0, 0, 1'b1, 1'b1);
    chk({nm, " ready_in_done"}, int'(m_ready), 0);
    step();
    chk_px({nm, " idle_after"}, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    chk({nm, " ready_after"}, int'(m_ready), 1);
    sel = 1'b0;
  endtask

  typedef struct {
    string nm;
    int x0, x1, y0, y1, col;
    int exmin, exmax, eymin, eymax;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"basic_2x3",   2,   4,   3,   4, 'h5A,   2,   4,   3,   4};
    vecs[1] = '{"swap_x",     10,   7,   5,   5, 'h11,   7,  10,   5,   5};
    vecs[2] = '{"clamp_x",   398, 500, 299, 299, 'h22, 398, 399, 299, 299};
    vecs[3] = '{"swap_xy",     3,   1,  20,  18, 'h33,   1,   3,  18,  20};
    vecs[4] = '{"clamp_y",     0,   0, 511, 297, 'hFF,   0,   0, 297, 299};
    vecs[5] = '{"one_px",      0,   0,   0,   0, 'h01,   0,   0,   0,   0};
    vecs[6] = '{"corner_1x1", 511, 450, 400, 310, 'h80, 399, 399, 299, 299};

    sel = 1'b0; valid_d = 1'b0; valid_s = 1'b0; reset_i = 1'b1;
    scramble();
    step(); step();
    chk_px("reset_outputs", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    chk("reset_ready", int'(d_ready), 0);
    reset_i = 1'b0;
    #1;
    chk("ready_after_reset", int'(d_ready), 1);

    foreach (vecs[i])
      run_fill(vecs[i].nm, 1'b0, vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1,
               vecs[i].col, vecs[i].exmin, vecs[i].exmax, vecs[i].eymin, vecs[i].eymax);

    // Back-to-back: valid held across both 1x1 commands.
    x0 = 9'd5; x1 = 9'd5; y0 = 9'd6; y1 = 9'd6; color = 8'h01; valid_d = 1'b1;
    step();
    chk_px("b2b first", 1'b1, 5, 6, 'h01, 1'b0, 1'b1);
    x0 = 9'd7; x1 = 9'd7; y0 = 9'd8; y1 = 9'd8; color = 8'h02;
    step();
    chk_px("b2b done1", 1'b0, 0, 0, 0, 1'b1, 1'b1);
    chk("b2b ready_in_done", int'(d_ready), 0);
    step();
    chk_px("b2b gap", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    chk("b2b ready_after_done", int'(d_ready), 1);
    step();
    valid_d = 1'b0;
    chk_px("b2b second", 1'b1, 7, 8, 'h02, 1'b0, 1'b1);
    step();
    chk_px("b2b done2", 1'b0, 0, 0, 0, 1'b1, 1'b1);
    step();
    chk_px("b2b idle", 1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Reset while the third write of a 4x4 fill is on the port.
    x0 = 9'd0; x1 = 9'd3; y0 = 9'd0; y1 = 9'd3; color = 8'h44; valid_d = 1'b1;
    step();
    valid_d = 1'b0;
    chk_px("rst w1", 1'b1, 0, 0, 'h44, 1'b0, 1'b1);
    step();
    chk_px("rst w2", 1'b1, 1, 0, 'h44, 1'b0, 1'b1);
    step();
    chk_px("rst w3", 1'b1, 2, 0, 'h44, 1'b0, 1'b1);
    reset_i = 1'b1;
    step();
    chk_px("rst applied", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    reset_i = 1'b0;
    #1;
    chk("rst ready_after_release", int'(d_ready), 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_px("rst quiet", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    end

    // Full-screen sweep on the small instance with out-of-range bounds.
    run_fill("full_screen", 1'b1, 0, 511, 0, 255, 'hC6, 0, 259, 0, 139);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rect_fill.md
RECT_FILL -- requirements
Module: rect_fill

Interface
REQ-001 Parameter RESOLUTION_X, default 400, framebuffer width in pixels.
REQ-002 Parameter RESOLUTION_Y, default 300, framebuffer height in pixels.
REQ-003 Parameter PALETTE_LENGTH, default 256, number of palette entries.
REQ-004 Port set SHALL be as follows; XW = $clog2(RESOLUTION_X), YW = $clog2(RESOLUTION_Y), CW = $clog2(PALETTE_LENGTH).
- clk_i  in  1  single clock; drives all logic; same clock as the framebuffer write port.
- reset_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  fill command present.
- cmd_ready_o  out  1  block accepts a command this cycle.
- cmd_x0_i, cmd_x1_i  in  XW  rectangle column bounds, inclusive, any order.
- cmd_y0_i, cmd_y1_i  in  YW  rectangle row bounds, inclusive, any order.
- cmd_color_i  in  CW  palette index to fill.
- we_o  out  1  pixel write strobe to framebuffer.
- wr_pxl_x_o  out  XW  write column.
- wr_pxl_y_o  out  YW  write row.
- wr_palette_index_o  out  CW  write data.
- busy_o  out  1  fill in progress.
- done_o  out  1  one-cycle pulse after the last pixel is written.

Function
REQ-005 A command SHALL be accepted on a clk_i edge where cmd_valid_i && cmd_ready_o.
REQ-006 cmd_ready_o SHALL be 1 only in state IDLE and SHALL be combinational from state.
REQ-007 On accept, all command fields SHALL be registered; inputs are don't-care afterwards.
REQ-008 On accept, each bound >= resolution SHALL be clamped to RESOLUTION-1 (X or Y respectively).
REQ-009 After clamping, if x0>x1 the bounds SHALL be swapped; likewise y0>y1.
REQ-010 States: IDLE -> FILL on accept; FILL -> DONE after the last pixel write; DONE -> IDLE unconditionally after one cycle.
REQ-011 The first we_o SHALL assert in the cycle after accept (latency 1), with x=xmin, y=ymin.
REQ-012 In FILL, exactly one pixel SHALL be written per cycle, with no gaps, in row-major order: x increments; at x==xmax, x wraps to xmin and y increments.
REQ-013 The last write SHALL be (xmax, ymax); total writes = (xmax-xmin+1)*(ymax-ymin+1).
REQ-014 wr_palette_index_o SHALL equal the registered color for every write.
REQ-015 Degenerate rectangle (xmin==xmax and/or ymin==ymax) SHALL be legal; a 1x1 command yields exactly one write.
REQ-016 done_o SHALL pulse high in the DONE cycle; cmd_ready_o SHALL be 0 in DONE, so back-to-back commands have a 2-cycle gap between last and first write.
REQ-017 busy_o SHALL be 1 in FILL and DONE, 0 in IDLE.
REQ-018 we_o, wr_pxl_x_o, wr_pxl_y_o and wr_palette_index_o SHALL be registered outputs; when we_o=0, all three data outputs SHALL be 0.
REQ-019 Counters SHALL be XW/YW bits wide; no write SHALL ever target x>=RESOLUTION_X or y>=RESOLUTION_Y.

Reset
REQ-020 While reset_i=1 at an edge: state=IDLE and all outputs 0 (cmd_ready_o becomes 1 after reset releases).
REQ-021 Reset during FILL SHALL abort the fill with no further writes and no done_o pulse.

Structure
REQ-022 The state enum (IDLE, FILL, DONE) SHALL be placed in shared package gpu_pkg; resolution/palette defaults SHALL remain module parameters.
REQ-023 Clamp and swap logic SHALL be a combinational sub-module rect_normalize, instantiated once for X and once for Y, with a width parameter.

Verification
REQ-024 Command (2,3)-(4,4), color 0x5A -> 6 writes on consecutive cycles starting 1 cycle after accept: (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), all 0x5A; done_o pulses 1 cycle later.
REQ-025 Command x0=10, x1=7, y0=5, y1=5 -> writes (7,5),(8,5),(9,5),(10,5).
REQ-026 Command x0=398, x1=500, y0=299, y1=299 -> exactly writes (398,299),(399,299).
REQ-027 Two commands held valid back to back (1x1 each) -> second accepted in the cycle after the done_o pulse; exactly 2 writes total.
REQ-028 Reset asserted on the 3rd write of a 4x4 fill -> no writes after the reset edge, done_o stays 0, cmd_ready_o=1 in the cycle after reset deasserts.
REQ-029 Full-screen fill (0,0)-(399,299) -> 120000 writes, no gaps, last at (399,299), done_o once.
